// File: rtl/dh_pkg.sv
// Shared types and constants for the Diffie-Hellman key sequencer.
package dh_pkg;

   localparam int DH_W_DEF = 32;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_CHKP = 3'd1,
      S_J_R1 = 3'd2,
      S_J_R2 = 3'd3,
      S_J_K1 = 3'd4,
      S_J_K2 = 3'd5,
      S_FIN  = 3'd6
   } dh_state_t;

   localparam logic [1:0] DH_OK   = 2'b00;
   localparam logic [1:0] DH_BADP = 2'b01;
   localparam logic [1:0] DH_TMO  = 2'b10;
   localparam logic [1:0] DH_MISM = 2'b11;

endpackage

// File: rtl/dh_job_timer.sv
// Per-job watchdog: loadable down-counter that flags expiry at terminal count.
module dh_job_timer #(
   parameter int TIMEOUT = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   output logic expired
);

   localparam int CW = 16;
   localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT);
   localparam logic [CW-1:0] ONE      = CW'(1);

   logic [CW-1:0] count;

   // Reload on job entry, then count down and park at zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (load) begin
         count <= LOAD_VAL;
      end else if (count != '0) begin
         count <= count - ONE;
      end
   end

   assign expired = (count == '0);

endmodule

// File: rtl/dh_key_ctrl.sv
// Diffie-Hellman exchange sequencer sharing one mod-exp engine between both parties.
// Optional build macro DH_KEY_CHECK_EN: compare K1 against K2 at the end of a run
// and report a mismatch on err.
//
// state  | meaning
// -------+---------------------------------------------------------
// IDLE   | waiting for st; operands latched on acceptance
// CHKP   | reject modulus below 2
// J_R1   | engine job g^x mod p
// J_R2   | engine job g^y mod p
// J_K1   | engine job R2^x mod p (published key)
// J_K2   | engine job R1^y mod p, plus one cycle to settle K2 before FIN
// FIN    | done pulse, back to IDLE
module dh_key_ctrl
   import dh_pkg::*;
#(
   parameter int W       = DH_W_DEF,
   parameter int TIMEOUT = 1024
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         st,
   input  logic [W-1:0] g,
   input  logic [W-1:0] p,
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   output logic         eng_start,
   output logic [W-1:0] eng_base,
   output logic [W-1:0] eng_exp,
   output logic [W-1:0] eng_mod,
   input  logic         eng_done,
   input  logic [W-1:0] eng_result,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] r1,
   output logic [W-1:0] r2,
   output logic [W-1:0] key,
   output logic [1:0]   err
);

   dh_state_t    state, state_nx;
   logic [W-1:0] g_q, p_q, x_q, y_q, k2_q;
   logic         start_ok, bad_p, job_state, enter_job;
   logic         tmo_exp, tmo_hit, k2_got;

   assign start_ok  = (state == S_IDLE) && st;
   assign bad_p     = (p_q < W'(2));
   assign job_state = (state == S_J_R1) || (state == S_J_R2) ||
                      (state == S_J_K1) || (state == S_J_K2);
   // A done arriving in the expiry cycle wins over the timeout.
   assign tmo_hit   = job_state && !k2_got && !eng_done && tmo_exp;

   dh_job_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .load    (enter_job),
      .expired (tmo_exp)
   );

   // Next-state decode; enter_job marks every transition into an engine job.
   always_comb begin
      state_nx  = state;
      enter_job = 1'b0;
      case (state)
         S_IDLE: if (st) state_nx = S_CHKP;
         S_CHKP: begin
            if (bad_p) begin
               state_nx = S_FIN;
            end else begin
               state_nx  = S_J_R1;
               enter_job = 1'b1;
            end
         end
         S_J_R1: begin
            if (eng_done) begin
               state_nx  = S_J_R2;
               enter_job = 1'b1;
            end else if (tmo_exp) begin
               state_nx = S_FIN;
            end
         end
         S_J_R2: begin
            if (eng_done) begin
               state_nx  = S_J_K1;
               enter_job = 1'b1;
            end else if (tmo_exp) begin
               state_nx = S_FIN;
            end
         end
         S_J_K1: begin
            if (eng_done) begin
               state_nx  = S_J_K2;
               enter_job = 1'b1;
            end else if (tmo_exp) begin
               state_nx = S_FIN;
            end
         end
         S_J_K2: begin
            // K2 lands in k2_q first so FIN can compare registered values.
            if (k2_got) begin
               state_nx = S_FIN;
            end else if (!eng_done && tmo_exp) begin
               state_nx = S_FIN;
            end
         end
         S_FIN:   state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // State register; eng_start is a registered one-cycle pulse on job entry.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         eng_start <= 1'b0;
         k2_got    <= 1'b0;
      end else begin
         state     <= state_nx;
         eng_start <= enter_job;
         k2_got    <= (state == S_J_K2) && !k2_got && eng_done;
      end
   end

   // Operand latch, per-job result capture and error reporting.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         g_q  <= '0;
         p_q  <= '0;
         x_q  <= '0;
         y_q  <= '0;
         r1   <= '0;
         r2   <= '0;
         key  <= '0;
         k2_q <= '0;
         err  <= DH_OK;
      end else begin
         if (start_ok) begin
            g_q  <= g;
            p_q  <= p;
            x_q  <= x;
            y_q  <= y;
            r1   <= '0;
            r2   <= '0;
            key  <= '0;
            k2_q <= '0;
            err  <= DH_OK;
         end
         if ((state == S_CHKP) && bad_p) err <= DH_BADP;
         if ((state == S_J_R1) && eng_done) r1 <= eng_result;
         if ((state == S_J_R2) && eng_done) r2 <= eng_result;
         if ((state == S_J_K1) && eng_done) key <= eng_result;
         if ((state == S_J_K2) && eng_done && !k2_got) k2_q <= eng_result;
         if (tmo_hit) err <= DH_TMO;
`ifdef DH_KEY_CHECK_EN
         if (k2_got && (k2_q != key)) err <= DH_MISM;
`endif
      end
   end

`ifndef DH_KEY_CHECK_EN
   // K2 is still captured in this build but nothing consumes it.
   logic k2_unused;
   assign k2_unused = ^k2_q;
`endif

   // Job operand select; R1/R2 are stable while the K jobs run.
   always_comb begin
      eng_base = '0;
      eng_exp  = '0;
      eng_mod  = '0;
      case (state)
         S_J_R1: begin eng_base = g_q; eng_exp = x_q; eng_mod = p_q; end
         S_J_R2: begin eng_base = g_q; eng_exp = y_q; eng_mod = p_q; end
         S_J_K1: begin eng_base = r2;  eng_exp = x_q; eng_mod = p_q; end
         S_J_K2: begin eng_base = r1;  eng_exp = y_q; eng_mod = p_q; end
         default: ;
      endcase
   end

   assign busy = (state != S_IDLE) && (state != S_FIN);
   assign done = (state == S_FIN);

endmodule

// File: tb/tb_dh_key_ctrl.sv
module tb_dh_key_ctrl;
   import dh_pkg::*;

   localparam int W  = 32;
   localparam int TO = 20;
`ifdef DH_KEY_CHECK_EN
   localparam logic [1:0] MISM_EXP = DH_MISM;
`else
   localparam logic [1:0] MISM_EXP = DH_OK;
`endif

   logic         clk = 1'b0;
   logic         rst, st;
   logic [W-1:0] g, p, x, y;
   logic         eng_start;
   logic [W-1:0] eng_base, eng_exp, eng_mod;
   logic         eng_done;
   logic [W-1:0] eng_result;
   logic         busy, done;
   logic [W-1:0] r1, r2, key;
   logic [1:0]   err;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   dh_key_ctrl #(.W(W), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .st(st), .g(g), .p(p), .x(x), .y(y),
      .eng_start(eng_start), .eng_base(eng_base), .eng_exp(eng_exp), .eng_mod(eng_mod),
      .eng_done(eng_done), .eng_result(eng_result),
      .busy(busy), .done(done), .r1(r1), .r2(r2), .key(key), .err(err)
   );

   // Reference modular exponentiation by square-and-multiply.
   function automatic logic [31:0] modexp(input logic [31:0] b, input logic [31:0] e,
                                          input logic [31:0] m);
      logic [63:0] r, bb, mm;
      if (m == 32'd0) return 32'd0;
      mm = {32'd0, m};
      r  = 64'd1 % mm;
      bb = {32'd0, b} % mm;
      for (int i = 0; i < 32; i++) begin
         if (e[i]) r = (r * bb) % mm;
         bb = (bb * bb) % mm;
      end
      return r[31:0];
   endfunction

   // Behavioural engine: modes 0 normal, 1 never answers, 2 K2 forced to 0,
   // 3 answers only the first job.
   int           eng_lat = 1, eng_mode = 0, eng_cnt = 0, job_n = 0;
   bit           eng_busy = 1'b0, cur_silent = 1'b0;
   logic [W-1:0] cur_res;
   int           s_edge[$];
   logic [W-1:0] b_log[$], e_log[$], m_log[$];

   always @(posedge clk) begin : engine
      logic         smp;
      logic [W-1:0] b_s, e_s, m_s;
      smp = eng_start;
      b_s = eng_base;
      e_s = eng_exp;
      m_s = eng_mod;
      #1;
      eng_done   = 1'b0;
      eng_result = $urandom();
      if (rst === 1'b1) begin
         if (smp === 1'b1) begin
            s_edge.push_back(cyc);
            b_log.push_back(b_s);
            e_log.push_back(e_s);
            m_log.push_back(m_s);
            cur_res = modexp(b_s, e_s, m_s);
            if (eng_mode == 2 && job_n == 3) cur_res = '0;
            cur_silent = (eng_mode == 1) || (eng_mode == 3 && job_n >= 1);
            job_n++;
            eng_busy = 1'b1;
            eng_cnt  = eng_lat;
         end
         if (eng_busy) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
               eng_busy = 1'b0;
               if (!cur_silent) begin
                  eng_done   = 1'b1;
                  eng_result = cur_res;
               end
            end
         end
      end else begin
         eng_busy = 1'b0;
      end
   end

   always @(negedge rst) begin
      eng_busy = 1'b0;
      eng_done = 1'b0;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic eng_setup(input int lat, input int mode);
      eng_lat  = lat;
      eng_mode = mode;
      job_n    = 0;
      s_edge.delete();
      b_log.delete();
      e_log.delete();
      m_log.delete();
   endtask

   // One full exchange from st to done, checked against the reference model.
   task automatic do_run(input string tag, input logic [W-1:0] gi, input logic [W-1:0] pi,
                         input logic [W-1:0] xi, input logic [W-1:0] yi,
                         input int lat, input int mode, input bit repulse);
      logic [W-1:0] er1, er2, ek1;
      logic [W-1:0] eb[4], ee[4];
      logic [1:0]   eerr;
      int           a_edge, d_edge, fail_job, n_start, n_chk;
      bit           got;
      eng_setup(lat, mode);
      g = gi; p = pi; x = xi; y = yi;
      st = 1'b1;
      @(posedge clk); #1;
      st = 1'b0;
      a_edge = cyc;
      check({tag, "_busy_on"}, busy, 1);
      check({tag, "_cleared"}, r1 | r2 | key, 0);
      check({tag, "_err_clr"}, err, DH_OK);
      check({tag, "_no_start_chkp"}, eng_start, 0);
      got = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(posedge clk); #1;
         if (done === 1'b1) begin
            got = 1'b1;
            break;
         end
         st = repulse && (s_edge.size() == 2);
      end
      st = 1'b0;
      d_edge = cyc;
      check({tag, "_done_seen"}, got, 1);
      er1 = modexp(gi, xi, pi);
      er2 = modexp(gi, yi, pi);
      ek1 = modexp(er2, xi, pi);
      eb  = '{gi, gi, er2, er1};
      ee  = '{xi, yi, xi, yi};
      if (pi < 2) begin
         check({tag, "_lat"}, 64'(d_edge - a_edge), 1);
         check({tag, "_err"}, err, DH_BADP);
         check({tag, "_outs"}, r1 | r2 | key, 0);
         check({tag, "_starts"}, 64'(s_edge.size()), 0);
      end else begin
         fail_job = 4;
         if (mode == 1 || lat > TO) fail_job = 0;
         else if (mode == 3) fail_job = 1;
         n_start = (fail_job < 4) ? fail_job + 1 : 4;
         if (fail_job < 4) eerr = DH_TMO;
         else if (mode == 2) eerr = MISM_EXP;
         else eerr = DH_OK;
         check({tag, "_starts"}, 64'(s_edge.size()), 64'(n_start));
         check({tag, "_err"}, err, eerr);
         check({tag, "_r1"}, r1, (fail_job > 0) ? er1 : '0);
         check({tag, "_r2"}, r2, (fail_job > 1) ? er2 : '0);
         check({tag, "_key"}, key, (fail_job > 2) ? ek1 : '0);
         if (fail_job < 4) begin
            if (s_edge.size() > fail_job)
               check({tag, "_tmo_lat"}, 64'(d_edge - s_edge[fail_job]), 64'(TO));
         end else begin
            check({tag, "_lat"}, 64'(d_edge - a_edge), 64'(4 * lat + 6));
         end
         if (s_edge.size() > 0) check({tag, "_first_start"}, 64'(s_edge[0] - a_edge), 2);
         n_chk = (s_edge.size() < 4) ? s_edge.size() : 4;
         for (int k = 0; k < n_chk; k++) begin
            check($sformatf("%s_base%0d", tag, k), b_log[k], eb[k]);
            check($sformatf("%s_exp%0d", tag, k), e_log[k], ee[k]);
            check($sformatf("%s_mod%0d", tag, k), m_log[k], pi);
            if (k > 0) check($sformatf("%s_gap%0d", tag, k), 64'(s_edge[k] - s_edge[k-1]), 64'(lat + 1));
         end
      end
      check({tag, "_busy_at_done"}, busy, 0);
      @(posedge clk); #1;
      check({tag, "_done_once"}, done, 0);
      check({tag, "_idle"}, busy, 0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] rg, rp, rx, ry, r1_hold;
      int           n_prev;
      bit           hit;
      rst = 1'b0; st = 1'b0;
      g = '0; p = '0; x = '0; y = '0;
      eng_done = 1'b0; eng_result = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_eng_start", eng_start, 0);
      check("rst_results", r1 | r2 | key, 0);
      check("rst_err", err, 0);
      check("rst_operands", eng_base | eng_exp | eng_mod, 0);
      rst = 1'b1;
      @(posedge clk); #1;

      do_run("spec", 17, 5, 6, 3, 3, 0, 0);
      check("spec_r1_const", r1, 4);
      check("spec_r2_const", r2, 3);
      check("spec_key_const", key, 4);

      do_run("badp1", 32'h1234, 1, 5, 6, 3, 0, 0);
      do_run("badp0", 32'h99, 0, 7, 2, 3, 0, 0);
      do_run("p2", 32'hDEAD_BEEF, 2, 32'h7, 32'h0, 2, 0, 0);

      for (int i = 0; i < 6; i++) begin
         rg = $urandom();
         rp = $urandom();
         if (rp < 2) rp = 2;
         rx = ($urandom_range(0, 3) == 0) ? '0 : $urandom();
         ry = $urandom();
         do_run($sformatf("rnd%0d", i), rg, rp, rx, ry, $urandom_range(1, 8), 0, 0);
      end

      do_run("lat_eq_to", 32'h1234_5678, 32'hFFFF_FFFB, 32'h55, 32'h66, TO, 0, 0);
      do_run("lat_gt_to", 17, 5, 6, 3, TO + 1, 0, 0);
      do_run("silent", 17, 5, 6, 3, 3, 1, 0);
      do_run("silent_r2", 17, 5, 6, 3, 3, 3, 0);
      check("silent_r2_r1_const", r1, 4);
      do_run("k2_bad", 17, 5, 6, 3, 3, 2, 0);
      check("k2_bad_key_const", key, 4);

      // Spurious engine completion while idle.
      r1_hold = r1;
      n_prev  = s_edge.size();
      #1;
      eng_done = 1'b1;
      @(posedge clk); #1;
      check("spur_busy", busy, 0);
      check("spur_r1", r1, r1_hold);
      repeat (3) @(posedge clk);
      #1;
      check("spur_no_start", 64'(s_edge.size()), 64'(n_prev));
      check("spur_idle", busy | done, 0);

      do_run("repulse", 17, 5, 6, 3, 3, 0, 1);
      repeat (4) @(posedge clk);
      #1;
      check("repulse_no_restart", 64'(s_edge.size()), 4);
      check("repulse_idle", busy, 0);

      // Reset in the first cycle of the K1 job.
      eng_setup(5, 0);
      g = 17; p = 5; x = 6; y = 3;
      st = 1'b1;
      @(posedge clk); #1;
      st = 1'b0;
      hit = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if (eng_start === 1'b1 && s_edge.size() == 2) begin
            hit = 1'b1;
            break;
         end
      end
      check("rstk1_reached", hit, 1);
      check("rstk1_results_live", (r1 == 4) && (r2 == 3), 1);
      #2;
      rst = 1'b0;
      #1;
      check("rstk1_eng_start", eng_start, 0);
      check("rstk1_busy_done", busy | done, 0);
      check("rstk1_results", r1 | r2 | key, 0);
      check("rstk1_err", err, 0);
      @(posedge clk);
      #3;
      rst = 1'b1;
      @(posedge clk); #1;
      do_run("after_rst", 17, 5, 6, 3, 4, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/dh_key_ctrl.md
# dh_key_ctrl

Sequencer for a Diffie-Hellman exchange that time-shares one external modular-exponentiation engine (result = base^exp mod mod) between the two parties. On a start pulse it latches g, p and the two private exponents x and y. It then runs four engine jobs in fixed order: R1 = g^x mod p, R2 = g^y mod p, K1 = R2^x mod p, K2 = R1^y mod p. It publishes R1, R2 and the shared key, and sits between the top-level key-exchange wrapper and the engine.

## Interface
- W, 32: operand/result width.
- TIMEOUT, 1024: max cycles to wait for eng_done per job; 1..2^16-1.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- st  in  1  start pulse; sampled only in IDLE.
- g  in  W  generator.
- p  in  W  prime modulus.
- x  in  W  party-1 private exponent.
- y  in  W  party-2 private exponent.
- eng_start  out  1  one-cycle job request.
- eng_base / eng_exp / eng_mod  out  W each  job operands; held stable from eng_start until eng_done.
- eng_done  in  1  one-cycle completion pulse; eng_result valid in the same cycle.
- eng_result  in  W  engine result.
- busy  out  1  high from the cycle after accepted st until done.
- done  out  1  one-cycle completion pulse.
- r1, r2, key  out  W  public values and shared key (key = K1).
- err  out  2  00 ok, 01 bad parameter, 10 timeout, 11 key mismatch.

## Operation
- States: IDLE, CHKP, J_R1, J_R2, J_K1, J_K2, FIN.
- Transitions:
  - IDLE goes to CHKP on st=1. g, p, x and y are latched on that edge.
  - CHKP: if p<2, go to FIN with err=01. Otherwise go to J_R1.
  - J_*: assert eng_start in the first cycle of the state only. On eng_done, capture eng_result and advance: R1, then R2, then K1, then K2, then FIN.
- Operands per job:
  - R1 uses (g, x, p).
  - R2 uses (g, y, p).
  - K1 uses (captured R2, x, p).
  - K2 uses (captured R1, y, p).
- Per-job timeout counter:
  - Cleared on entry to each J_* state.
  - If it reaches TIMEOUT without eng_done, go to FIN with err=10.
  - r1, r2 and key keep whatever was captured before the timeout.
- FIN: done=1 for one cycle, busy drops, then go to IDLE.
- st while not in IDLE is ignored and never queued.
- eng_done outside a J_* state is ignored.
- An eng_done in the same cycle as the timeout expiry counts as completion, not timeout.
- g and x are not pre-reduced; the engine handles base >= p. Exponent 0 is legal, and the engine returns 1 mod p.
- Outputs r1, r2 and key update only on their own job's eng_done. They hold between runs. A new accepted st clears them to 0.

## Timing
- Reset values: all outputs 0, state IDLE, counter 0. Reset can be asserted mid-job; the controller drops eng_start immediately. The engine is reset from the same rst.
- st accepted at edge n:
  - busy=1 and state CHKP from cycle n+1.
  - eng_start=1 in cycle n+2.
- Engine latency L cycles: eng_done arrives L cycles after eng_start. The next job's eng_start follows eng_done after exactly one cycle in which eng_start stays low.
- Total st-to-done latency for a clean run is 4L+7 cycles.
- Bad parameter: done is asserted in cycle n+2.

## Configuration
- Macro DH_KEY_CHECK_EN.
- Defined: FIN compares K1 and K2. A mismatch reports err=11; key still holds K1.
- Undefined: no comparison, K2 is captured but unused, and err never reads 11.
- Latency is identical in both builds.

## Structure
- Shared package dh_pkg holds:
  - the state enum type,
  - the err code constants (DH_OK, DH_BADP, DH_TMO, DH_MISM),
  - the default W.
- Sub-module dh_job_timer: loadable down-counter with expire flag, parameterised by TIMEOUT.
- Everything else is flat in dh_key_ctrl.

## Test plan
- g=17, p=5, x=6, y=3, behavioural engine with L=3: expect r1=4, r2=3, key=4, err=00, done at st+19 cycles.
- p=1 with st: done at st+2 cycles, err=01, eng_start never asserted, outputs 0.
- Engine that never answers, TIMEOUT=20: done 21 cycles after the first eng_start, err=10, r1 unchanged.
- With DH_KEY_CHECK_EN, engine model corrupts K2 to 0: err=11, key=4. Without the macro, the same run gives err=00.
- st re-pulsed during J_R2, plus a spurious eng_done in IDLE: no restart, single done, results as in the first scenario.
- rst asserted during J_K1: all outputs 0 asynchronously. A fresh st then completes normally.
